// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter driving a 2-to-4 decoder (addr1, addr0, enable).
// Fair rotation via a priority pointer, an optional hold-time limit with
// a one-cycle timeout pulse, and a guaranteed one-cycle enable-low gap
// between any two grants. All outputs come straight from flops.

module rr_decoder_arbiter #(
  parameter int MAX_HOLD = 8,  // 0 = a grant may be held indefinitely
  parameter int CNT_W    = 4   // must satisfy 2**CNT_W > MAX_HOLD
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  output logic addr0,
  output logic addr1,
  output logic enable,
  output logic timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
  localparam bit               HOLD_ON    = (MAX_HOLD != 0);

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic [3:0]       req;
  logic             any_req;
  logic             granted_req;
  logic             at_limit;
  logic [1:0]       pick;
  logic [1:0]       scan_idx;
  logic             found;

  assign req         = {req3, req2, req1, req0};
  assign any_req     = |req;
  assign granted_req = req[addr_q];
  // Only meaningful while in GRANT; cnt_q counts cycles the grant has been high.
  assign at_limit    = HOLD_ON && (cnt_q == HOLD_LIMIT);

  // Priority pick: first asserted request scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  always_comb begin
    pick     = ptr_q;
    scan_idx = ptr_q;
    found    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!found && req[scan_idx]) begin
        pick  = scan_idx;
        found = 1'b1;
      end
    end
  end

  // State register; reset drops enable immediately since enable is decoded from it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a grant always returns through IDLE, which creates the gap cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = GRANT;
      GRANT:   if (!granted_req || at_limit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: address load, pointer advance, hold count, timeout.
  always_comb begin
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          addr_d = pick;
          cnt_d  = CNT_W'(1);
        end
      end
      GRANT: begin
        if (!granted_req) begin
          // Normal release takes precedence over a coincident hold limit.
          ptr_d = addr_q + 2'd1;
        end else if (at_limit) begin
          ptr_d     = addr_q + 2'd1;
          timeout_d = 1'b1;
        end else if (cnt_q != '1) begin
          // Saturating so an unlimited hold never wraps the counter.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q     <= 2'd0;
      addr_q    <= 2'd0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign addr0   = addr_q[0];
  assign addr1   = addr_q[1];
  assign enable  = (state_q == GRANT);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Bench for rr_decoder_arbiter: four instances (MAX_HOLD = 8, 2, 4, 0)
// share clock, reset and requests. A behavioural model predicts
// {enable, addr1, addr0, timeout} per instance each cycle; predictions are
// queued when stimulus is driven and popped when outputs are sampled.

module tb_rr_decoder_arbiter;

  localparam int W = 4;

  logic       clk;
  logic       reset;
  logic [3:0] req_v;
  logic [3:0] en_w, a0_w, a1_w, to_w;

  int hold_lim[4] = '{8, 2, 4, 0};

  // model state per instance
  bit m_grant[4];
  int m_idx[4];
  int m_ptr[4];
  int m_held[4];
  bit m_to[4];

  logic [W-1:0] exp_q[$];

  int n_checks;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int HV = (g == 0) ? 8 : (g == 1) ? 2 : (g == 2) ? 4 : 0;
    rr_decoder_arbiter #(.MAX_HOLD(HV), .CNT_W(4)) u_dut (
      .clk    (clk),
      .reset  (reset),
      .req0   (req_v[0]),
      .req1   (req_v[1]),
      .req2   (req_v[2]),
      .req3   (req_v[3]),
      .addr0  (a0_w[g]),
      .addr1  (a1_w[g]),
      .enable (en_w[g]),
      .timeout(to_w[g])
    );
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  task automatic model_reset(input int k);
    m_grant[k] = 1'b0;
    m_idx[k]   = 0;
    m_ptr[k]   = 0;
    m_held[k]  = 0;
    m_to[k]    = 1'b0;
  endtask

  task automatic model_step(input int k, input logic [3:0] r);
    int j;
    m_to[k] = 1'b0;
    if (!m_grant[k]) begin
      if (r != 4'b0000) begin
        j = m_ptr[k];
        while (!r[j]) j = (j + 1) % 4;
        m_idx[k]   = j;
        m_grant[k] = 1'b1;
        m_held[k]  = 1;
      end
    end else if (!r[m_idx[k]]) begin
      m_grant[k] = 1'b0;
      m_ptr[k]   = (m_idx[k] + 1) % 4;
    end else if (hold_lim[k] != 0 && m_held[k] >= hold_lim[k]) begin
      m_grant[k] = 1'b0;
      m_ptr[k]   = (m_idx[k] + 1) % 4;
      m_to[k]    = 1'b1;
    end else begin
      m_held[k]++;
    end
  endtask

  function automatic logic [W-1:0] model_out(input int k);
    return {m_grant[k], 2'(m_idx[k]), m_to[k]};
  endfunction

  // ---------------- driver ----------------
  // Drive one cycle of requests, predict, then compare just after the edge.
  task automatic cycle(input logic [3:0] r);
    logic [W-1:0] e;
    @(negedge clk);
    req_v = r;
    for (int k = 0; k < 4; k++) begin
      if (reset) model_reset(k);
      else       model_step(k, r);
      exp_q.push_back(model_out(k));
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (exp_q.size() == 0) begin
        check($sformatf("queue_empty_h%0d", hold_lim[k]), 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("out_h%0d", hold_lim[k]),
              {28'd0, en_w[k], a1_w[k], a0_w[k], to_w[k]}, {28'd0, e});
      end
    end
  endtask

  task automatic cycles(input logic [3:0] r, input int n);
    for (int i = 0; i < n; i++) cycle(r);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    req_v    = 4'b1111;
    for (int k = 0; k < 4; k++) model_reset(k);

    // reset held with all requests high
    cycles(4'b1111, 2);
    check("reset_outputs", {28'd0, en_w[0], a1_w[0], a0_w[0], to_w[0]}, 32'd0);

    // first edge after release grants requester 0
    reset = 1'b0;
    cycle(4'b1111);
    check("first_grant", {29'd0, en_w[0], a1_w[0], a0_w[0]}, 32'b100);
    cycle(4'b0000);

    // single requester 2 for three cycles, then ptr must sit at 3
    cycles(4'b0100, 3);
    cycle(4'b0000);
    cycle(4'b1001);
    check("ptr_after_req2", {29'd0, en_w[0], a1_w[0], a0_w[0]}, 32'b111);
    cycles(4'b0000, 2);

    // rotation with all requests high
    cycles(4'b1111, 24);
    cycles(4'b0000, 2);

    // timeout boundary on requester 1, then a drop coinciding with the limit
    cycles(4'b0010, 14);
    cycles(4'b0000, 2);
    cycles(4'b0010, 4);
    cycles(4'b0000, 2);
    cycles(4'b0010, 2);
    cycles(4'b0000, 2);

    // long hold on requester 3 (unlimited instance must never wrap)
    cycles(4'b1000, 40);
    cycles(4'b0000, 2);

    // asynchronous reset in the middle of a grant
    cycles(4'b0100, 2);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_enable", {28'd0, en_w}, 32'd0);
    check("async_reset_timeout", {28'd0, to_w}, 32'd0);
    cycle(4'b0011);
    reset = 1'b0;
    cycle(4'b0011);
    check("grant_after_reset", {29'd0, en_w[0], a1_w[0], a0_w[0]}, 32'b100);
    cycles(4'b0000, 2);

    // random request patterns held for random lengths
    for (int i = 0; i < 50; i++) begin
      cycles(4'($urandom_range(0, 15)), $urandom_range(1, 9));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_decoder_arbiter.md
Name: rr_decoder_arbiter

Overview:
- Sequential round-robin arbiter sitting directly upstream of the 2-to-4 structural decoder.
- Takes four request lines and drives the decoder's addr0, addr1 and enable, so exactly one decoder output is asserted for the granted requester.
- Enforces fair rotation, a bounded hold time, and a mandatory one-cycle all-outputs-low gap between grants (break-before-make on the decoder outputs).

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles a grant may be held; 0 = unlimited.
- CNT_W, 4, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  request from requester 0.
- req1  input  1  request from requester 1.
- req2  input  1  request from requester 2.
- req3  input  1  request from requester 3.
- addr0  output  1  decoder address LSB; granted index = {addr1,addr0}.
- addr1  output  1  decoder address MSB.
- enable  output  1  decoder enable; high only while a grant is active.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked at MAX_HOLD.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high: clk and reset, all state cleared immediately on reset assertion, independent of clk.
- All outputs are registered; no combinational path from req* to any output.
- Reset values:
  - addr0=0, addr1=0, enable=0, timeout=0.
  - Priority pointer ptr=0 (req0 highest priority).
  - Hold counter cnt=0; state=IDLE.
- State IDLE (enable=0):
  - At each rising edge, if any req is high, choose the first asserted request scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Load {addr1,addr0} with that index, set enable=1, cnt=1, go to GRANT.
  - If no req is high, stay in IDLE; addr holds its last value.
- Latency: a req sampled high at edge N in IDLE gives enable=1 after edge N, i.e. one cycle.
- State GRANT (enable=1), evaluated at each rising edge, in priority order:
  1. If req[granted] is low: release. enable=0, ptr=granted+1 mod 4, go to IDLE. Other requests are ignored at this edge, which produces the one-cycle gap.
  2. Else if MAX_HOLD!=0 and cnt==MAX_HOLD: forced release. enable=0, timeout=1 for exactly one cycle, ptr=granted+1 mod 4, go to IDLE.
  3. Else: hold. cnt=cnt+1 with no wrap; cnt is unused when MAX_HOLD=0 and saturates at all-ones.
- Requests from non-granted requesters never affect addr or enable during GRANT.
- addr0/addr1 change only on the edge that enters GRANT. They are stable for the whole grant and while in IDLE.
- enable is low for at least one full cycle between any two grants, including a re-grant of the same requester.
- ptr wrap-around: after granting 3, ptr=0.
- Simultaneous events:
  - req[granted] drop and cnt==MAX_HOLD on the same edge is a normal release, with timeout=0.
  - All four reqs high: grants rotate 0,1,2,3,0,... with a gap cycle between each.
- Reset mid-grant: enable falls asynchronously with reset, ptr returns to 0 and timeout clears. The first grant after reset release follows the IDLE rules.
- timeout is 0 in every cycle except the one following a forced release.

Test Plan:
- Reset check: assert reset with req0..3=1 -> addr=00, enable=0, timeout=0 while reset is held; first edge after release -> enable=1, addr=00.
- Single requester: req2=1 for 3 cycles then 0 (MAX_HOLD=8) -> enable=1 with addr=10 for 3 cycles, then enable=0; ptr=3, verified by next asserting req0 and req3 together -> addr=11 granted.
- Rotation: req0..3 held high, MAX_HOLD=2 -> grant sequence 00,01,10,11,00 with each grant 2 cycles, timeout pulse after each, and 1 enable-low cycle between grants.
- Timeout boundary: req1 held high, MAX_HOLD=4 -> enable high exactly 4 cycles, timeout=1 for 1 cycle, then re-grant of addr=01 after a 1-cycle gap; req1 dropping on the 4th edge instead -> timeout stays 0.
- MAX_HOLD=0: req3 held high for 40 cycles -> enable stays high with addr=11 throughout, timeout never asserts, no counter wrap effect.
- Async reset mid-grant: reset asserted between edges during a grant -> enable drops before the next clk edge; after release, req1 and req0 both high -> addr=00 granted first.
